fifo_led_sched: RTL
===================

# fifo_led_sched

Read-side controller for the UART receive FIFO. It decides when a byte is popped from the FIFO: on a debounced button press, or automatically when auto mode is compiled in and selected. It latches each popped byte onto the board LEDs, holds it visible for a programmable time, counts displayed bytes, and keeps a sticky FIFO-error flag. It sits between the FIFO's read port and the LED pins, replacing direct button-to-`i_rd` wiring.

## Interface
- `HOLD_CYCLES`, default 24'd1_200_000: minimum cycles a displayed byte is held before the next pop; legal range ≥ 1.
- `CW`, default 24: width of the hold timer.
- `i_clk` in 1: system clock.
- `i_rst_n` in 1: reset, asynchronous, active-low.
- `i_req_man` in 1: one-cycle manual pop request (button press pulse).
- `i_auto` in 1: level, selects auto-drain mode; ignored when auto is compiled out.
- `i_clr` in 1: one-cycle pulse; clears `o_err`, `o_count` and `o_pending`.
- `i_fifo_empty_n` in 1: FIFO holds ≥ 1 byte.
- `i_fifo_data` in 8: FIFO head byte, first-word-fall-through (valid while `i_fifo_empty_n` = 1).
- `i_fifo_err` in 1: FIFO overflow/underflow pulse.
- `o_fifo_rd` out 1: pop strobe, exactly one cycle per byte.
- `o_leds` out 8: last popped byte.
- `o_err` out 1: sticky FIFO error.
- `o_pending` out 1: a manual request is waiting.
- `o_busy` out 1: state ≠ IDLE.
- `o_count` out 8: bytes popped, mod 256.

## Operation
- **States:** IDLE, POP, HOLD. Reset value is IDLE.
- **Request:** `req = i_req_man | pending`, or `(i_auto & auto compiled in)`. Manual and auto pop the same FIFO, so no further priority is needed.
- **IDLE:** if `req` and `i_fifo_empty_n`, go to POP and clear pending.
- **Manual press with FIFO empty:** sets pending. Pending persists until granted or until `i_clr`.
- **POP:** lasts one cycle with `o_fifo_rd` = 1.
  - At the closing edge: `o_leds` ← `i_fifo_data`; `o_count` ← `o_count + 1` (0xFF wraps to 0x00); timer ← `HOLD_CYCLES - 1`; go to HOLD.
  - This block is the FIFO's only reader, so empty_n sampled in IDLE guarantees data in POP.
- **HOLD:** the timer decrements each cycle; at 0, go to IDLE.
  - `i_req_man` during POP or HOLD sets pending (single-deep; extra presses are absorbed).
- **`o_err`:** set on any cycle with `i_fifo_err` = 1. Set wins over a simultaneous `i_clr`.
- **`i_clr`:** does not change state, `o_leds` or the timer. If `i_clr` arrives in the same cycle as a POP edge, the count becomes 0, not 1. If `i_clr` coincides with `i_req_man`, pending is 0 afterwards, but that press is still granted if IDLE and data are present.
- **Reset:** all outputs and internal registers are 0; state is IDLE. An active reset mid-POP or mid-HOLD aborts immediately. A pop in progress is lost at the FIFO side only if `o_fifo_rd` was already sampled.

## Timing
- Registered outputs: `o_fifo_rd`, `o_leds`, `o_count`, `o_err`, `o_pending`.
- `o_busy` is decoded from the state register.
- Press sampled in IDLE at cycle N (data present):
  - `o_fifo_rd` = 1 in N+1.
  - `o_leds` and `o_count` updated from N+2.
  - HOLD for N+2 … N+1+HOLD_CYCLES.
  - IDLE at N+2+HOLD_CYCLES.
- Maximum throughput: 1 byte per HOLD_CYCLES + 2 cycles.
- `o_err` rises the cycle after `i_fifo_err`.
- `o_pending` rises the cycle after an ungranted press.

## Configuration
- `FIFO_LED_SCHED_AUTO_EN` defined: auto-drain logic is compiled in. With `i_auto` = 1, the block pops whenever it is IDLE and the FIFO is non-empty, paced by HOLD.
- Undefined: the auto path is absent and `i_auto` is unconnected internally. Pops occur only on manual requests.

## Test plan
Benches use HOLD_CYCLES = 4.

- **Reset:** assert `i_rst_n` = 0 with random inputs. Required: `o_leds` = 0x00, `o_count` = 0, `o_err` = `o_pending` = `o_fifo_rd` = `o_busy` = 0.
- **Manual pops:** FIFO holds 0x41, 0x42; pulse `i_req_man`.
  - Required: `o_fifo_rd` high 1 cycle; `o_leds` = 0x41 and `o_count` = 1 two cycles after the press.
  - A second press during HOLD sets `o_pending`. Required: 0x42 is displayed 6 cycles after the first, `o_pending` then 0, `o_count` = 2.
- **Press while empty:** press with FIFO empty. Required: `o_pending` = 1 and no `o_fifo_rd`. Then push 0x5A. Required: popped, `o_leds` = 0x5A, `o_pending` = 0.
- **Auto drain** (macro defined): 3 bytes 0x01..0x03 with `i_auto` = 1. Required: `o_fifo_rd` pulses every 6 cycles; after 18 cycles `o_count` = 3, `o_leds` = 0x03, block IDLE. Without the macro: no pops.
- **Error flag and count wrap:** pulse `i_fifo_err` with `i_clr` in the same cycle. Required: `o_err` = 1. A later `i_clr` alone gives `o_err` = 0. Preload 255 pops, then one more pop. Required: `o_count` = 0x00.
- **Reset mid-HOLD:** assert `i_rst_n` = 0 mid-HOLD. Required: `o_busy` and `o_leds` are 0 without waiting for a clock edge; after release the next press pops normally.

Source files
------------

// File: rtl/fifo_led_sched_if.sv
// FIFO read-port bundle between the UART receive FIFO and its LED-side reader.
// The reader (fifo_led_sched) uses the master modport; the FIFO side uses slave.
interface fifo_led_sched_if;
    logic       i_fifo_empty_n;
    logic [7:0] i_fifo_data;
    logic       i_fifo_err;
    logic       o_fifo_rd;

    modport master (
        input  i_fifo_empty_n,
        input  i_fifo_data,
        input  i_fifo_err,
        output o_fifo_rd
    );

    modport slave (
        output i_fifo_empty_n,
        output i_fifo_data,
        output i_fifo_err,
        input  o_fifo_rd
    );
endinterface

// File: rtl/fifo_led_sched.sv
// Read-side scheduler for the UART RX FIFO: pops on button press (or auto-drain when
// FIFO_LED_SCHED_AUTO_EN is defined), shows each byte on the LEDs for HOLD_CYCLES.
module fifo_led_sched #(
    parameter int            CW          = 24,
    parameter logic [CW-1:0] HOLD_CYCLES = 24'd1_200_000
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    fifo_led_sched_if.master         fifo,
    input  logic                     i_req_man,
    input  logic                     i_auto,
    input  logic                     i_clr,
    output logic [7:0]               o_leds,
    output logic                     o_err,
    output logic                     o_pending,
    output logic                     o_busy,
    output logic [7:0]               o_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [CW-1:0] HOLD_RELOAD = CW'(HOLD_CYCLES - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] timer_q, timer_d;
    logic [7:0]    leds_q, leds_d;
    logic [7:0]    count_q, count_d;
    logic          pending_q, pending_d;
    logic          err_q, err_d;
    logic          rd_q, rd_d;
    logic          auto_req;
    logic          req;

`ifdef FIFO_LED_SCHED_AUTO_EN
    assign auto_req = i_auto;
`else
    logic unused_auto;
    assign unused_auto = i_auto;
    assign auto_req    = 1'b0;
`endif

    assign req = i_req_man | pending_q | auto_req;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            leds_q    <= '0;
            count_q   <= '0;
            pending_q <= 1'b0;
            err_q     <= 1'b0;
            rd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            leds_q    <= leds_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            err_q     <= err_d;
            rd_q      <= rd_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        leds_d    = leds_q;
        count_d   = count_q;
        pending_d = pending_q;
        err_d     = err_q;
        rd_d      = 1'b0;

        case (state_q)
            IDLE: begin
                // rd is registered, so it is raised here to be high exactly during POP
                if (req && fifo.i_fifo_empty_n) begin
                    state_d   = POP;
                    rd_d      = 1'b1;
                    pending_d = 1'b0;
                end else if (i_req_man) begin
                    pending_d = 1'b1;
                end
            end
            POP: begin
                leds_d  = fifo.i_fifo_data;
                count_d = count_q + 8'd1;
                timer_d = HOLD_RELOAD;
                state_d = HOLD;
                if (i_req_man) pending_d = 1'b1;
            end
            HOLD: begin
                if (timer_q == '0) state_d = IDLE;
                else               timer_d = timer_q - CW'(1);
                if (i_req_man) pending_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // Clear overrides the POP increment and any pending press, but not a new error.
        if (i_clr) begin
            count_d   = '0;
            pending_d = 1'b0;
        end
        if (fifo.i_fifo_err) err_d = 1'b1;
        else if (i_clr)      err_d = 1'b0;
    end

    assign fifo.o_fifo_rd = rd_q;
    assign o_leds         = leds_q;
    assign o_count        = count_q;
    assign o_err          = err_q;
    assign o_pending      = pending_q;
    assign o_busy         = (state_q != IDLE);

endmodule
